// File: rtl/lfsr_16bit_checker.sv
// ---------------------------------------------------------------------------
// lfsr_16bit_checker
//
// Receives the 16-bit word stream of a Fibonacci LFSR generator, locks onto
// it, and then checks every later word against its own prediction. A word
// that is corrupted in transit raises an error. The checker keeps predicting
// from its own state, so one bad word does not spoil the words after it.
//
// Optional feature (macro LFSR_CHK_FIRST_ERR_EN):
//   When defined, the received and expected words of the first LOCKED
//   mismatch are captured and held until reset or clear. When undefined,
//   the first_err_* ports are tied to zero.
//
// Ports:
//   clk_i           in   1      clock, rising edge
//   rst_ni          in   1      asynchronous active-low reset
//   valid_i         in   1      data_i carries a new word this cycle
//   data_i          in   16     word from the generator
//   clear_i         in   1      synchronous clear of counters and state
//   locked_o        out  1      checker is in LOCKED
//   err_o           out  1      one-cycle pulse on a mismatching checked word
//   err_cnt_o       out  CNT_W  saturating count of LOCKED mismatches
//   word_cnt_o      out  CNT_W  saturating count of words checked in LOCKED
//   first_err_got_o out  16     data_i of the first mismatch
//   first_err_exp_o out  16     expected word at the first mismatch
// ---------------------------------------------------------------------------
module lfsr_16bit_checker #(
    parameter logic [15:0] TAPS     = 16'hB400,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [15:0]      data_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] word_cnt_o,
    output logic [15:0]      first_err_got_o,
    output logic [15:0]      first_err_exp_o
);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_LOCKING,
        ST_LOCKED
    } state_e;

    localparam logic [7:0]       LOCK_TGT = 8'(LOCK_CNT);
    localparam logic [7:0]       LOSS_TGT = 8'(LOSS_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & TAPS)};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    state_e           state_q, state_d;
    logic [15:0]      exp_q, exp_d;
    logic [7:0]       match_q, match_d;
    logic [7:0]       miss_q, miss_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    // Word the source should send next, given the last accepted word.
    logic [15:0] pred;
    logic        hit;

    assign pred = lfsr_next(exp_q);
    assign hit  = (data_i == pred);

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        match_d    = match_q;
        miss_d     = miss_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        word_cnt_d = word_cnt_q;

        if (clear_i) begin
            state_d    = ST_UNLOCKED;
            exp_d      = 16'h0000;
            match_d    = 8'd0;
            miss_d     = 8'd0;
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end else if (valid_i) begin
            case (state_q)
                ST_UNLOCKED: begin
                    // All-zero is the LFSR lock-up value and cannot seed.
                    if (data_i != 16'h0000) begin
                        exp_d   = data_i;
                        match_d = 8'd0;
                        state_d = ST_LOCKING;
                    end
                end
                ST_LOCKING: begin
                    exp_d = data_i;
                    if (hit) begin
                        match_d = match_q + 8'd1;
                        if (match_q + 8'd1 >= LOCK_TGT) begin
                            state_d = ST_LOCKED;
                            miss_d  = 8'd0;
                        end
                    end else begin
                        match_d = 8'd0;
                        if (data_i == 16'h0000) begin
                            state_d = ST_UNLOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Free-run on the prediction, not on the received word.
                    exp_d      = pred;
                    word_cnt_d = sat_inc(word_cnt_q);
                    if (hit) begin
                        miss_d = 8'd0;
                    end else begin
                        err_d     = 1'b1;
                        err_cnt_d = sat_inc(err_cnt_q);
                        miss_d    = miss_q + 8'd1;
                        if (miss_q + 8'd1 >= LOSS_TGT) begin
                            state_d = ST_UNLOCKED;
                            miss_d  = 8'd0;
                        end
                    end
                end
                default: state_d = ST_UNLOCKED;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_UNLOCKED;
            exp_q      <= 16'h0000;
            match_q    <= 8'd0;
            miss_q     <= 8'd0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign locked_o   = (state_q == ST_LOCKED);
    assign err_o      = err_q;
    assign err_cnt_o  = err_cnt_q;
    assign word_cnt_o = word_cnt_q;

`ifdef LFSR_CHK_FIRST_ERR_EN
    logic        first_seen_q, first_seen_d;
    logic [15:0] first_got_q, first_got_d;
    logic [15:0] first_exp_q, first_exp_d;

    always_comb begin
        first_seen_d = first_seen_q;
        first_got_d  = first_got_q;
        first_exp_d  = first_exp_q;
        if (clear_i) begin
            first_seen_d = 1'b0;
            first_got_d  = 16'h0000;
            first_exp_d  = 16'h0000;
        end else if (valid_i && state_q == ST_LOCKED && !hit && !first_seen_q) begin
            first_seen_d = 1'b1;
            first_got_d  = data_i;
            first_exp_d  = pred;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            first_seen_q <= 1'b0;
            first_got_q  <= 16'h0000;
            first_exp_q  <= 16'h0000;
        end else begin
            first_seen_q <= first_seen_d;
            first_got_q  <= first_got_d;
            first_exp_q  <= first_exp_d;
        end
    end

    assign first_err_got_o = first_got_q;
    assign first_err_exp_o = first_exp_q;
`else
    assign first_err_got_o = 16'h0000;
    assign first_err_exp_o = 16'h0000;
`endif

endmodule

// File: tb/tb_lfsr_16bit_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_16bit_checker
//
// Directed bench for lfsr_16bit_checker. A behavioural model tracks the
// length of the current LFSR chain in the received words and, once locked,
// predicts each word by stepping forward from the word where lock was taken.
// A negedge process compares every DUT output with the model each cycle, and
// hand-computed literals pin the key scenario points.
// Counters are built narrow (CNT_W = 4) so that saturation is reached.
// ---------------------------------------------------------------------------
module tb_lfsr_16bit_checker;

    localparam int          CNT_W    = 4;
    localparam int          LOCK_CNT = 4;
    localparam int          LOSS_CNT = 3;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;
    localparam logic [15:0] TAPS     = 16'hB400;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             vld = 1'b0;
    logic             clr = 1'b0;
    logic [15:0]      dat = 16'h0000;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] word_cnt;
    logic [15:0]      first_got;
    logic [15:0]      first_exp;

    lfsr_16bit_checker #(
        .TAPS     (TAPS),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .valid_i         (vld),
        .data_i          (dat),
        .clear_i         (clr),
        .locked_o        (locked),
        .err_o           (err),
        .err_cnt_o       (err_cnt),
        .word_cnt_o      (word_cnt),
        .first_err_got_o (first_got),
        .first_err_exp_o (first_exp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & TAPS)};
    endfunction

    function automatic logic [15:0] advance(input logic [15:0] s, input int n);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < n; i++) r = lfsr_step(r);
        return r;
    endfunction

    bit          m_locked;
    bit          m_err;
    int          m_err_cnt;
    int          m_word_cnt;
    int          m_chain;     // words in the current unbroken LFSR chain
    logic [15:0] m_last;
    logic [15:0] m_base;      // word at which lock was taken
    int          m_steps;     // words consumed since lock
    int          m_miss;
    bit          m_first_seen;
    logic [15:0] m_first_got;
    logic [15:0] m_first_exp;

    task automatic model_reset();
        m_locked = 0; m_err = 0; m_err_cnt = 0; m_word_cnt = 0;
        m_chain = 0; m_last = 16'h0; m_base = 16'h0; m_steps = 0; m_miss = 0;
        m_first_seen = 0; m_first_got = 16'h0; m_first_exp = 16'h0;
    endtask

    task automatic model_update(input logic v, input logic [15:0] d, input logic c);
        logic [15:0] expw;
        m_err = 0;
        if (c) begin
            model_reset();
            return;
        end
        if (!v) return;
        if (!m_locked) begin
            if (d == 16'h0) m_chain = 0;
            else if (m_chain > 0 && d == lfsr_step(m_last)) m_chain++;
            else m_chain = 1;
            m_last = d;
            if (m_chain == LOCK_CNT + 1) begin
                m_locked = 1; m_base = d; m_steps = 0; m_miss = 0; m_chain = 0;
            end
        end else begin
            m_steps++;
            expw = advance(m_base, m_steps);
            if (m_word_cnt < CNT_MAX) m_word_cnt++;
            if (d == expw) begin
                m_miss = 0;
            end else begin
                m_err = 1;
                if (m_err_cnt < CNT_MAX) m_err_cnt++;
                m_miss++;
`ifdef LFSR_CHK_FIRST_ERR_EN
                if (!m_first_seen) begin
                    m_first_seen = 1; m_first_got = d; m_first_exp = expw;
                end
`endif
                if (m_miss == LOSS_CNT) begin
                    m_locked = 0; m_chain = 0; m_miss = 0;
                end
            end
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            check("locked",    32'(locked),    32'(m_locked));
            check("err",       32'(err),       32'(m_err));
            check("err_cnt",   32'(err_cnt),   32'(m_err_cnt));
            check("word_cnt",  32'(word_cnt),  32'(m_word_cnt));
            check("first_got", 32'(first_got), 32'(m_first_got));
            check("first_exp", 32'(first_exp), 32'(m_first_exp));
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [15:0] g;   // next clean word of the reference stream

    task automatic step(input logic v, input logic [15:0] d, input logic c);
        vld = v; dat = d; clr = c;
        @(posedge clk);
        model_update(v, d, c);
        @(negedge clk);
        vld = 1'b0; clr = 1'b0;
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, g, 1'b0);
            g = lfsr_step(g);
        end
    endtask

    task automatic apply_reset();
        check_en = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_en = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_locked",   32'(locked),   32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_err_cnt",  32'(err_cnt),  32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_en = 1'b1;

        // Lock on a clean stream from 0001, then saturate the word counter.
        g = 16'h0001;
        for (int i = 1; i <= 22; i++) begin
            step(1'b1, g, 1'b0);
            if (i == 4)  check("lock_w4", 32'(locked), 32'd0);
            if (i == 5)  check("lock_w5", 32'(locked), 32'd1);
            if (i == 12) begin
                check("w12_is_0801", 32'(g), 32'h0801);
                check("w12_err",     32'(err), 32'd0);
                check("w12_wcnt",    32'(word_cnt), 32'd7);
            end
            if (i == 22) check("wcnt_sat", 32'(word_cnt), 32'd15);
            g = lfsr_step(g);
        end
        check("clean_err_cnt", 32'(err_cnt), 32'd0);

        // Single-bit error.
        step(1'b1, g ^ 16'h0001, 1'b0);
        g = lfsr_step(g);
        check("sbe_err",     32'(err),     32'd1);
        check("sbe_err_cnt", 32'(err_cnt), 32'd1);
        check("sbe_locked",  32'(locked),  32'd1);
        clean(1);
        check("sbe_next_err", 32'(err), 32'd0);
        clean(4);
        check("sbe_final_cnt", 32'(err_cnt), 32'd1);

        // Loss of lock and re-lock.
        apply_reset();
        g = 16'h0001;
        clean(6);
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, g ^ 16'h8000, 1'b0);
            g = lfsr_step(g);
            if (i == 2) check("loss_w2_locked", 32'(locked), 32'd1);
        end
        check("loss_locked",  32'(locked),  32'd0);
        check("loss_err_cnt", 32'(err_cnt), 32'd3);
        clean(4);
        check("relock_w4", 32'(locked), 32'd0);
        clean(1);
        check("relock_w5", 32'(locked), 32'd1);

        // Zero words and a gapped stream.
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0000, 1'b0);
        check("zero_locked", 32'(locked), 32'd0);
        g = 16'h0001;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, g, 1'b0);
            if (i == 5) check("gap_lock_w5", 32'(locked), 32'd1);
            step(1'b0, g ^ 16'h5A5A, 1'b0);
            g = lfsr_step(g);
        end
        check("gap_locked",  32'(locked),  32'd1);
        check("gap_err_cnt", 32'(err_cnt), 32'd0);

        // Clear together with valid, then async reset mid-cycle.
        apply_reset();
        g = 16'h0001;
        clean(6);
        step(1'b1, g ^ 16'h0100, 1'b0); g = lfsr_step(g);
        clean(2);
        step(1'b1, g ^ 16'h0100, 1'b0); g = lfsr_step(g);
        clean(2);
        check("pre_clr_err_cnt", 32'(err_cnt), 32'd2);
        check("pre_clr_locked",  32'(locked),  32'd1);
        step(1'b1, g, 1'b1); g = lfsr_step(g);
        check("clr_locked",   32'(locked),   32'd0);
        check("clr_err_cnt",  32'(err_cnt),  32'd0);
        check("clr_word_cnt", 32'(word_cnt), 32'd0);
        clean(6);
        check("post_clr_locked", 32'(locked), 32'd1);
        check_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_locked",   32'(locked),   32'd0);
        check("arst_err_cnt",  32'(err_cnt),  32'd0);
        check("arst_word_cnt", 32'(word_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_en = 1'b1;
        clean(4);
        check("arst_relock_w4", 32'(locked), 32'd0);
        clean(1);
        check("arst_relock_w5", 32'(locked), 32'd1);

        // First-error capture: 0801 replaced by 0800, then a second error.
        apply_reset();
        g = 16'h0001;
        clean(11);
        step(1'b1, 16'h0800, 1'b0); g = lfsr_step(g);
`ifdef LFSR_CHK_FIRST_ERR_EN
        check("fe_got",  32'(first_got), 32'h0800);
        check("fe_exp",  32'(first_exp), 32'h0801);
`else
        check("fe_got0", 32'(first_got), 32'h0000);
        check("fe_exp0", 32'(first_exp), 32'h0000);
`endif
        clean(3);
        step(1'b1, g ^ 16'h0010, 1'b0); g = lfsr_step(g);
        clean(2);
        check("fe_err_cnt", 32'(err_cnt), 32'd2);
`ifdef LFSR_CHK_FIRST_ERR_EN
        check("fe_got_hold", 32'(first_got), 32'h0800);
        check("fe_exp_hold", 32'(first_exp), 32'h0801);
`else
        check("fe_got0_hold", 32'(first_got), 32'h0000);
        check("fe_exp0_hold", 32'(first_exp), 32'h0000);
`endif

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lfsr_16bit_checker.md
Name: lfsr_16bit_checker

Overview:
- Downstream consumer of lfsr_16bit: samples the 16-bit pseudo-random word stream, self-synchronises to it, then checks every subsequent word against a locally predicted sequence.
- Reports lock status, per-word error pulses and saturating error/word counters.
- Used in self-checking benches and on-chip BIST of the random source and the path it drives.

Parameters:
- TAPS, 16'hB400, feedback mask of the Fibonacci LFSR (bits 15,13,12,10 = x^16+x^14+x^13+x^11+1); must match the upstream generator.
- LOCK_CNT, 4, consecutive correct predictions required to enter LOCKED (1..255).
- LOSS_CNT, 3, consecutive mismatches in LOCKED that drop lock (1..255).
- CNT_W, 32, width of the error and word counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_i  in  1  data_i carries a new word this cycle (driven with the generator's en_i, delayed to match its output).
- data_i  in  16  word from the generator (its out_o).
- clear_i  in  1  synchronous clear of counters and state; returns to UNLOCKED.
- locked_o  out  1  checker is in LOCKED.
- err_o  out  1  one-cycle pulse: mismatch on a checked word.
- err_cnt_o  out  CNT_W  mismatches counted while LOCKED, saturating.
- word_cnt_o  out  CNT_W  words checked while LOCKED, saturating.
- first_err_got_o  out  16  data_i of first mismatch (optional feature).
- first_err_exp_o  out  16  expected word at first mismatch (optional feature).

Behaviour:
- Clock and reset: one clock clk_i; reset rst_ni is asynchronous and active-low.
- Reset values: all outputs 0, state UNLOCKED, internal expected register 0, match/miss counters 0.
- Prediction: next(s) = {s[14:0], ^(s & TAPS)}. exp holds the last accepted word.
- Only cycles with valid_i=1 advance anything; valid_i=0 holds all state, and err_o=0.
- Registered outputs: err_o, locked_o and the counters update on the clock edge after the valid word; latency is 1 cycle.
- UNLOCKED:
  - Nonzero data_i: exp<=data_i, match<=0, go to LOCKING.
  - data_i==0 (LFSR lock-up value): ignored, stay in UNLOCKED.
- LOCKING:
  - data_i==next(exp): exp<=data_i, match++; when match reaches LOCK_CNT, go to LOCKED, miss<=0.
  - Mismatch: reseed with exp<=data_i, match<=0; if data_i==0, go to UNLOCKED.
  - No err_o and no counting in this state.
- LOCKED:
  - Every valid word: word_cnt++ (saturating), exp<=next(exp). The checker free-runs on its own prediction, so a corrupted word does not corrupt later predictions.
  - Match: miss<=0.
  - Mismatch: err_o=1, err_cnt++ (saturating at all-ones), miss++.
  - When miss reaches LOSS_CNT: go to UNLOCKED with locked_o<=0. The word that triggers loss is still counted.
- clear_i:
  - Synchronous; highest priority over valid_i in the same cycle.
  - Zeroes both counters, err_o and the first-error registers; state goes to UNLOCKED.
- Asynchronous reset mid-stream: immediate return to reset values. After release the checker needs 1+LOCK_CNT valid words to re-lock.
- Counter saturation: at 2^CNT_W-1 a counter holds; it never wraps.

Optional Feature:
- Macro: LFSR_CHK_FIRST_ERR_EN.
- Defined: on the first LOCKED mismatch since reset/clear, capture data_i into first_err_got_o and next(exp) into first_err_exp_o. Later errors do not overwrite them. Cleared by reset or clear_i.
- Undefined: no capture registers; both ports tied to 16'h0000.

Test Plan:
- Lock, clean stream:
  - Stimulus: reset; stream from seed 16'h0001 (0001, 0002, 0004, 0008, 0010, …) with valid_i=1 every cycle.
  - Required: locked_o rises 1 cycle after the 5th word; err_cnt_o stays 0; word_cnt_o counts checked words. Through 16'h0400 -> 16'h0801 the prediction must match.
- Single-bit error:
  - Stimulus: once locked, replace one word with its value XOR 16'h0001.
  - Required: err_o pulses exactly once, err_cnt_o=1, locked_o stays 1. The following correct words produce no further errors.
- Loss of lock:
  - Stimulus: once locked, send 3 consecutive wrong words.
  - Required: err_cnt_o=3, locked_o falls after the 3rd. A subsequent clean stream re-locks after 5 words.
- Zero and gap handling:
  - Stimulus: reset, then data_i=0 with valid_i=1 for 4 cycles; then a clean stream with valid_i toggling 1/0.
  - Required: the zero words leave the checker UNLOCKED; with the gapped stream it locks with no errors.
- Clear and async reset:
  - Stimulus: with err_cnt_o=2 and LOCKED, assert clear_i together with valid_i; later pull rst_ni low mid-cycle.
  - Required: after clear, counters=0 and UNLOCKED. During reset, outputs go 0 immediately, without waiting for a clock edge.
- Optional-feature check:
  - Stimulus: with LFSR_CHK_FIRST_ERR_EN defined, inject expected 16'h0801 replaced by 16'h0800, then a second error.
  - Required: first_err_got_o=16'h0800, first_err_exp_o=16'h0801, both unchanged after the second error.
  - Without the macro: both ports read 0.
